gray_stream_decoder: RTL and testbench
======================================

// Module: gray_stream_decoder
// PURPOSE
//  Receiving end of a Gray-coded count link (e.g. a pointer crossing from another block).
//  Accepts Gray samples over valid/ready and converts each to binary.
//  Checks that consecutive samples differ by at most one bit, reports the step direction,
//  and locks into FAULT after too many illegal steps. Output is a single registered stage.
// PARAMETERS
//  WIDTH    4  bit width of the Gray/binary code (>=2)
//  MAX_ERR  3  illegal steps counted before entering FAULT (1..7)
// PORTS
//  clk         in   1      clock; all logic on rising edge
//  rst_n       in   1      synchronous active-low reset
//  clear       in   1      1-cycle pulse: return to IDLE, zero err_cnt
//  in_gray     in   WIDTH  Gray-coded sample
//  in_valid    in   1      in_gray valid
//  in_ready    out  1      decoder can accept a sample
//  out_bin     out  WIDTH  binary value of the accepted sample
//  out_dir     out  1      1 = count up, 0 = count down (last legal step)
//  out_err     out  1      sample was an illegal step (Hamming distance > 1)
//  out_valid   out  1      out_* valid
//  out_ready   in   1      sink accepts out_*
//  err_cnt     out  3      saturating count of illegal steps since reset/clear
//  locked      out  1      1 while in FAULT
// BEHAVIOUR
//  Reset (rst_n=0 at an edge): state=IDLE, all outputs 0 except in_ready=1; rst_n overrides clear.
//  Accept = in_valid & in_ready. Output regs are updated on an accept; out_valid is high from the next cycle.
//  in_ready = locked | ~out_valid | out_ready. This allows one accept per cycle under continuous out_ready.
//  Hold rule: while out_valid & ~out_ready, all out_* are held stable.
//  Conversion: bin[W-1] = g[W-1]; bin[i] = bin[i+1] ^ g[i]. Registered last_gray and last_bin hold the previous accepted sample.
//  States:
//   IDLE : on the first accept, emit the binary value with out_dir=1 and out_err=0; load last_*; go to TRACK.
//   TRACK: d = popcount(in_gray ^ last_gray) for each accept.
//     d==0 -> repeat: emit, keep the previous out_dir, out_err=0.
//     d==1 -> legal: out_dir=1 if new_bin == last_bin+1 mod 2^W, else 0; out_err=0.
//     d>1  -> emit with out_err=1 and out_dir unchanged; err_cnt+1 (saturates at 7).
//             last_* resyncs to the new sample. If the new err_cnt==MAX_ERR, go to FAULT.
//   FAULT: locked=1, in_ready=1; accepted samples are dropped. out_valid drops once the pending
//          output is taken. Leave only via clear.
//  Wrap-around: up/down across 2^W-1 <-> 0 is a legal step (Gray codes differ by the MSB only).
//  clear (any state): next cycle state=IDLE, err_cnt=0, locked=0, out_valid=0.
//   A sample accepted in the same cycle as clear is dropped.
//  Latency: 1 cycle from accept to out_valid. No combinational in->out path except in_ready<-out_ready.
// TESTING (WIDTH=4, MAX_ERR=3)
//  1 Hold rst_n=0 for 2 cycles -> out_valid=0, err_cnt=0, locked=0, in_ready=1; release -> IDLE.
//  2 Stream 0000,0001,0011,0010 with out_ready=1 -> out_bin 0,1,2,3 each 1 cycle later, out_dir=1, out_err=0.
//  3 Stream 1000,0000,1000 -> out_bin 15,0 with dir=1, then 15 with dir=0; no errors; 0000,0000 -> repeat, dir held.
//  4 Stream 0000,0011,0000,0101 -> out_err=1 on samples 2-4, err_cnt=3, locked=1. Further samples
//     -> in_ready=1 and no out_valid. clear -> locked=0, err_cnt=0; next sample handled as in IDLE.
//  5 out_ready=0 after the first output -> in_ready=0 and out_bin is stable for 5 cycles.
//     Raise out_ready -> one transfer per cycle, no sample lost or duplicated.
//  6 Drive rst_n=0 mid-stream, then assert clear together with in_valid -> outputs return
//     to their reset values; the sample sent with clear is dropped.

Source files
------------

// File: rtl/gray_stream_decoder.sv
// Gray-coded count receiver: converts accepted Gray samples to binary, classifies each step
// as repeat / legal / illegal, reports direction, and locks into FAULT after too many errors.
module gray_stream_decoder #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MAX_ERR = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [WIDTH-1:0] in_gray,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_bin,
  output logic             out_dir,
  output logic             out_err,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       err_cnt,
  output logic             locked
);

  typedef enum logic [1:0] {StIdle, StTrack, StFault} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] out_bin_q, out_bin_d;
  logic             out_dir_q, out_dir_d;
  logic             out_err_q, out_err_d;
  logic             out_valid_q, out_valid_d;
  logic [2:0]       err_cnt_q, err_cnt_d;
  logic [WIDTH-1:0] last_gray_q, last_gray_d;
  logic [WIDTH-1:0] last_bin_q, last_bin_d;

  logic [WIDTH-1:0] new_bin;
  logic [WIDTH-1:0] bin_inc;
  logic [WIDTH-1:0] diff;
  logic [2:0]       err_cnt_inc;
  logic             accept;
  logic             step_zero;
  logic             step_one;

  assign locked   = (state_q == StFault);
  assign in_ready = locked | ~out_valid_q | out_ready;
  assign accept   = in_valid & in_ready;

  // Binary bit i is the XOR of all Gray bits at or above i.
  always_comb begin
    new_bin = '0;
    for (int i = 0; i < WIDTH; i++) begin
      new_bin[i] = ^(in_gray >> i);
    end
  end

  assign diff        = in_gray ^ last_gray_q;
  assign step_zero   = (diff == '0);
  // Exactly one bit set: nonzero and clearing the lowest set bit leaves nothing.
  assign step_one    = !step_zero && ((diff & (diff - WIDTH'(1))) == '0);
  assign bin_inc     = last_bin_q + WIDTH'(1);
  assign err_cnt_inc = (err_cnt_q == 3'd7) ? err_cnt_q : err_cnt_q + 3'd1;

  always_comb begin
    state_d     = state_q;
    out_bin_d   = out_bin_q;
    out_dir_d   = out_dir_q;
    out_err_d   = out_err_q;
    out_valid_d = out_valid_q;
    err_cnt_d   = err_cnt_q;
    last_gray_d = last_gray_q;
    last_bin_d  = last_bin_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (clear) begin
      state_d     = StIdle;
      out_bin_d   = '0;
      out_dir_d   = 1'b0;
      out_err_d   = 1'b0;
      out_valid_d = 1'b0;
      err_cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            out_bin_d   = new_bin;
            out_dir_d   = 1'b1;
            out_err_d   = 1'b0;
            out_valid_d = 1'b1;
            last_gray_d = in_gray;
            last_bin_d  = new_bin;
            state_d     = StTrack;
          end
        end
        StTrack: begin
          if (accept) begin
            out_bin_d   = new_bin;
            out_valid_d = 1'b1;
            out_err_d   = 1'b0;
            last_gray_d = in_gray;
            last_bin_d  = new_bin;
            if (step_one) begin
              out_dir_d = (new_bin == bin_inc);
            end else if (!step_zero) begin
              out_err_d = 1'b1;
              err_cnt_d = err_cnt_inc;
              if (err_cnt_inc == 3'(MAX_ERR)) begin
                state_d = StFault;
              end
            end
          end
        end
        StFault: begin
          // Samples are accepted and discarded; only clear leaves this state.
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      out_bin_q   <= '0;
      out_dir_q   <= 1'b0;
      out_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
      err_cnt_q   <= '0;
      last_gray_q <= '0;
      last_bin_q  <= '0;
    end else begin
      state_q     <= state_d;
      out_bin_q   <= out_bin_d;
      out_dir_q   <= out_dir_d;
      out_err_q   <= out_err_d;
      out_valid_q <= out_valid_d;
      err_cnt_q   <= err_cnt_d;
      last_gray_q <= last_gray_d;
      last_bin_q  <= last_bin_d;
    end
  end

  assign out_bin   = out_bin_q;
  assign out_dir   = out_dir_q;
  assign out_err   = out_err_q;
  assign out_valid = out_valid_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_gray_stream_decoder.sv
// Bench for gray_stream_decoder: per-cycle vector table plus a back-pressured streaming run.
module tb_gray_stream_decoder;

  logic       clk = 1'b0;
  logic       rst_n, clear, in_valid, in_ready, out_ready;
  logic [3:0] in_gray, out_bin;
  logic       out_dir, out_err, out_valid, locked;
  logic [2:0] err_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  gray_stream_decoder #(.WIDTH(4), .MAX_ERR(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_gray   (in_gray),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_bin   (out_bin),
    .out_dir   (out_dir),
    .out_err   (out_err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err_cnt   (err_cnt),
    .locked    (locked)
  );

  typedef struct {
    string      name;
    logic       rst_n, clear, in_valid;
    logic [3:0] in_gray;
    logic       out_ready;
    logic       rdy;       // in_ready before the edge
    logic       ov;        // registered outputs after the edge
    logic [3:0] bin;
    logic       dir, err;
    logic [2:0] cnt;
    logic       lk;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input string n, input logic r, input logic c, input logic v,
                              input logic [3:0] g, input logic o, input logic rdy,
                              input logic ov, input logic [3:0] b, input logic d,
                              input logic e, input logic [2:0] cnt, input logic lk);
    vec_t x;
    x.name = n; x.rst_n = r; x.clear = c; x.in_valid = v; x.in_gray = g; x.out_ready = o;
    x.rdy = rdy; x.ov = ov; x.bin = b; x.dir = d; x.err = e; x.cnt = cnt; x.lk = lk;
    vecs.push_back(x);
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  int idx, rcv, cyc;
  logic take;

  initial begin
    // name rst clr vld gray or | rdy ov bin dir err cnt lk
    add("reset",      0, 0, 0, 4'b0000, 1, 1, 0, 4'd0,  0, 0, 0, 0);
    add("idle",       1, 0, 0, 4'b0000, 1, 1, 0, 4'd0,  0, 0, 0, 0);
    add("s0",         1, 0, 1, 4'b0000, 1, 1, 1, 4'd0,  1, 0, 0, 0);
    add("s1",         1, 0, 1, 4'b0001, 1, 1, 1, 4'd1,  1, 0, 0, 0);
    add("s2",         1, 0, 1, 4'b0011, 1, 1, 1, 4'd2,  1, 0, 0, 0);
    add("s3",         1, 0, 1, 4'b0010, 1, 1, 1, 4'd3,  1, 0, 0, 0);
    add("clear1",     1, 1, 0, 4'b0000, 1, 1, 0, 4'd0,  0, 0, 0, 0);
    add("w15",        1, 0, 1, 4'b1000, 1, 1, 1, 4'd15, 1, 0, 0, 0);
    add("wrap_up",    1, 0, 1, 4'b0000, 1, 1, 1, 4'd0,  1, 0, 0, 0);
    add("wrap_dn",    1, 0, 1, 4'b1000, 1, 1, 1, 4'd15, 0, 0, 0, 0);
    add("rep_dn",     1, 0, 1, 4'b1000, 1, 1, 1, 4'd15, 0, 0, 0, 0);
    add("wrap_up2",   1, 0, 1, 4'b0000, 1, 1, 1, 4'd0,  1, 0, 0, 0);
    add("rep_up",     1, 0, 1, 4'b0000, 1, 1, 1, 4'd0,  1, 0, 0, 0);
    add("clear2",     1, 1, 0, 4'b0000, 1, 1, 0, 4'd0,  0, 0, 0, 0);
    add("e_first",    1, 0, 1, 4'b0000, 1, 1, 1, 4'd0,  1, 0, 0, 0);
    add("err1",       1, 0, 1, 4'b0011, 1, 1, 1, 4'd2,  1, 1, 1, 0);
    add("err2",       1, 0, 1, 4'b0000, 1, 1, 1, 4'd0,  1, 1, 2, 0);
    add("err3_lock",  1, 0, 1, 4'b0101, 1, 1, 1, 4'd6,  1, 1, 3, 1);
    add("fault_hold", 1, 0, 1, 4'b0001, 0, 1, 1, 4'd6,  1, 1, 3, 1);
    add("fault_take", 1, 0, 1, 4'b0011, 1, 1, 0, 4'd6,  1, 1, 3, 1);
    add("fault_drop", 1, 0, 1, 4'b0000, 0, 1, 0, 4'd6,  1, 1, 3, 1);
    add("clear3",     1, 1, 0, 4'b0000, 1, 1, 0, 4'd0,  0, 0, 0, 0);
    add("post_clr",   1, 0, 1, 4'b0010, 1, 1, 1, 4'd3,  1, 0, 0, 0);
    for (int k = 0; k < 5; k++)
      add("stall",    1, 0, 1, 4'b0110, 0, 0, 1, 4'd3,  1, 0, 0, 0);
    add("release",    1, 0, 1, 4'b0110, 1, 1, 1, 4'd4,  1, 0, 0, 0);
    add("next5",      1, 0, 1, 4'b0111, 1, 1, 1, 4'd5,  1, 0, 0, 0);
    add("drain",      1, 0, 0, 4'b0000, 1, 1, 0, 4'd5,  1, 0, 0, 0);
    add("next6",      1, 0, 1, 4'b0101, 1, 1, 1, 4'd6,  1, 0, 0, 0);
    add("mid_reset",  0, 0, 1, 4'b0100, 0, 0, 0, 4'd0,  0, 0, 0, 0);
    add("clr_drop",   1, 1, 1, 4'b1100, 1, 1, 0, 4'd0,  0, 0, 0, 0);
    add("quiet",      1, 0, 0, 4'b0000, 1, 1, 0, 4'd0,  0, 0, 0, 0);
    add("idle_again", 1, 0, 1, 4'b0001, 1, 1, 1, 4'd1,  1, 0, 0, 0);
    add("step_dn",    1, 0, 1, 4'b0000, 1, 1, 1, 4'd0,  0, 0, 0, 0);
    add("err_dirhld", 1, 0, 1, 4'b0011, 1, 1, 1, 4'd2,  0, 1, 1, 0);
    add("rep_noerr",  1, 0, 1, 4'b0011, 1, 1, 1, 4'd2,  0, 0, 1, 0);

    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_gray = '0; out_ready = 1'b1;
    @(posedge clk);

    foreach (vecs[k]) begin
      @(negedge clk);
      rst_n     = vecs[k].rst_n;
      clear     = vecs[k].clear;
      in_valid  = vecs[k].in_valid;
      in_gray   = vecs[k].in_gray;
      out_ready = vecs[k].out_ready;
      #1;
      check({vecs[k].name, "_rdy"}, 16'(in_ready), 16'(vecs[k].rdy));
      @(posedge clk);
      #1;
      check(vecs[k].name, 16'({out_valid, out_bin, out_dir, out_err, err_cnt, locked}),
            16'({vecs[k].ov, vecs[k].bin, vecs[k].dir, vecs[k].err, vecs[k].cnt, vecs[k].lk}));
    end

    // Continuous up-count stream with intermittent back-pressure: every value exactly once.
    @(negedge clk);
    clear = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    idx = 0; rcv = 0; cyc = 0;
    while (rcv < 16 && cyc < 200) begin
      in_valid  = (idx < 16);
      in_gray   = 4'(idx ^ (idx >> 1));
      out_ready = (cyc % 3) != 2;
      #1;
      if (out_valid && out_ready) begin
        check("stream_bin", 16'(out_bin), 16'(rcv));
        check("stream_flags", 16'({out_dir, out_err}), 16'b10);
        rcv++;
      end
      take = in_valid && in_ready;
      @(posedge clk);
      if (take) idx++;
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    check("stream_count", 16'(rcv), 16'd16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
